// File: rtl/vga_sync_timing_pkg.sv
// rtl/vga_sync_timing_pkg.sv - shared VGA timing defaults, vertical state encoding and decode helper
package vga_sync_timing_pkg;

    // Default 256x240 timing; H_TOTAL = 321 pixels, V_TOTAL = 262 lines.
    localparam int DEF_H_ACTIVE = 256;
    localparam int DEF_H_FRONT  = 8;
    localparam int DEF_H_SYNC   = 32;
    localparam int DEF_H_BACK   = 25;
    localparam int DEF_V_ACTIVE = 240;
    localparam int DEF_V_FRONT  = 3;
    localparam int DEF_V_SYNC   = 4;
    localparam int DEF_V_BACK   = 15;
    localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

    typedef enum logic [1:0] {
        VS_ACT  = 2'd0,
        VS_FP   = 2'd1,
        VS_SYNC = 2'd2,
        VS_BP   = 2'd3
    } vstate_t;

    // Region a given line number belongs to; the FSM must always agree with this.
    function automatic vstate_t vstate_of(input logic [9:0] y,
                                          input logic [9:0] fp_start,
                                          input logic [9:0] sync_start,
                                          input logic [9:0] bp_start);
        if (y < fp_start)        return VS_ACT;
        else if (y < sync_start) return VS_FP;
        else if (y < bp_start)   return VS_SYNC;
        else                     return VS_BP;
    endfunction

endpackage

// File: rtl/vga_sync_timing_vertical_counter.sv
// rtl/vga_sync_timing_vertical_counter.sv - line counter advanced by h_line_end, wraps at V_TOTAL-1
//
// Ports:
//   clk        in   pixel clock
//   reset      in   synchronous active-high reset, clears y
//   h_line_end in   one-clk pulse on the last column of each line
//   y          out  current line number, 0..V_TOTAL-1
//   last_line  out  1 while y == V_TOTAL-1
module vertical_counter
    import vga_sync_timing_pkg::*;
#(
    parameter int V_TOTAL = DEF_V_TOTAL
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       h_line_end,
    output logic [9:0] y,
    output logic       last_line
);

    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

    logic [9:0] r_y;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_y <= '0;
        end else if (h_line_end) begin
            r_y <= (r_y == V_LAST) ? 10'd0 : r_y + 10'd1;
        end
    end

    assign y         = r_y;
    assign last_line = (r_y == V_LAST);

endmodule

// File: rtl/vga_sync_timing.sv
// rtl/vga_sync_timing.sv - registered hsync/vsync/video_on/coordinates and frame_end from pixel_x
//
// Ports:
//   clk        in   pixel clock, shared with horizontal_counter
//   reset      in   synchronous active-high reset
//   pixel_x    in   current column from horizontal_counter
//   h_line_end in   last column of the line, one clk wide
//   hsync      out  horizontal sync at SYNC_POL active level
//   vsync      out  vertical sync at SYNC_POL active level
//   video_on   out  1 inside the visible area
//   x_out      out  pixel_x delayed one clk
//   y_out      out  line number belonging to x_out
//   frame_end  out  one-clk pulse with the last pixel of the last line
module vga_sync_timing
    import vga_sync_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FRONT  = DEF_H_FRONT,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BACK   = DEF_H_BACK,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FRONT  = DEF_V_FRONT,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BACK   = DEF_V_BACK,
    parameter int SYNC_POL = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] pixel_x,
    input  logic       h_line_end,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic [9:0] x_out,
    output logic [9:0] y_out,
    output logic       frame_end
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024)
            $error("vga_sync_timing: H_TOTAL and V_TOTAL must not exceed 1024");
        if (H_ACTIVE < 1 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
            V_ACTIVE < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1)
            $error("vga_sync_timing: every timing parameter must be >= 1");
        if (SYNC_POL != 0 && SYNC_POL != 1)
            $error("vga_sync_timing: SYNC_POL must be 0 or 1");
    endgenerate

    // The hsync window ends before H_TOTAL, so an out-of-range pixel_x
    // naturally decodes as blanking with sync inactive.
    localparam logic [9:0] HACT_END   = 10'(H_ACTIVE);
    localparam logic [9:0] HS_START   = 10'(H_ACTIVE + H_FRONT);
    localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [9:0] VFP_START  = 10'(V_ACTIVE);
    localparam logic [9:0] VS_START   = 10'(V_ACTIVE + V_FRONT);
    localparam logic [9:0] VBP_START  = 10'(V_ACTIVE + V_FRONT + V_SYNC);
    localparam logic       POL        = (SYNC_POL != 0);

    logic [9:0] w_y;
    logic       w_last_line;
    logic [9:0] w_y_next;
    logic       w_hs_act;
    logic       w_vs_act;
    logic       w_vid;
    vstate_t    r_vstate;

    vertical_counter #(
        .V_TOTAL (V_TOTAL)
    ) u_vcnt (
        .clk        (clk),
        .reset      (reset),
        .h_line_end (h_line_end),
        .y          (w_y),
        .last_line  (w_last_line)
    );

    // Line number the counter will hold after this h_line_end.
    assign w_y_next = w_last_line ? 10'd0 : w_y + 10'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_vstate <= VS_ACT;
        end else if (h_line_end) begin
            case (r_vstate)
                VS_ACT:  if (w_y_next == VFP_START) r_vstate <= VS_FP;
                VS_FP:   if (w_y_next == VS_START)  r_vstate <= VS_SYNC;
                VS_SYNC: if (w_y_next == VBP_START) r_vstate <= VS_BP;
                VS_BP:   if (w_y_next == 10'd0)     r_vstate <= VS_ACT;
                default: r_vstate <= VS_ACT;
            endcase
        end
    end

    assign w_hs_act = (pixel_x >= HS_START) && (pixel_x < HS_END);
    assign w_vid    = (pixel_x < HACT_END) && (r_vstate == VS_ACT);
    assign w_vs_act = (r_vstate == VS_SYNC);

    always_ff @(posedge clk) begin
        if (reset) begin
            hsync     <= ~POL;
            vsync     <= ~POL;
            video_on  <= 1'b0;
            x_out     <= '0;
            y_out     <= '0;
            frame_end <= 1'b0;
        end else begin
            hsync     <= w_hs_act ? POL : ~POL;
            vsync     <= w_vs_act ? POL : ~POL;
            video_on  <= w_vid;
            x_out     <= pixel_x;
            // Pre-update y: the last pixel of a line still reports that line.
            y_out     <= w_y;
            frame_end <= h_line_end && w_last_line;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (r_vstate == vstate_of(w_y, VFP_START, VS_START, VBP_START))
                else $error("vga_sync_timing: vstate disagrees with line counter");
        end
    end

endmodule
